// File: rtl/maa_pipe_adder_if.sv
// Handshake bundle for maa_pipe_adder: upstream operand channel, downstream result channel
// and the completed-transfer counter.
interface maa_pipe_adder_if #(
   parameter int LOG2_WIDTH = 4,
   parameter int WIDTH      = 2**LOG2_WIDTH,
   parameter int M_MAX      = 8,
   parameter int LANES      = 1,
   parameter int CNT_W      = 16
);
   localparam int OPW = LOG2_WIDTH + WIDTH - 1;
   localparam int M_W = $clog2(M_MAX + 1);
   localparam int XW  = WIDTH - 1;
   localparam int KW  = LOG2_WIDTH + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [M_W-1:0]        in_m;
   logic [LANES*OPW-1:0]  in_op1;
   logic [LANES*OPW-1:0]  in_op2;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES*XW-1:0]   out_x;
   logic [LANES*KW-1:0]   out_k;
   logic [CNT_W-1:0]      txn_count;

   modport slave (
      input  in_valid, in_m, in_op1, in_op2, out_ready,
      output in_ready, out_valid, out_x, out_k, txn_count
   );

   modport master (
      output in_valid, in_m, in_op1, in_op2, out_ready,
      input  in_ready, out_valid, out_x, out_k, txn_count
   );
endinterface

// File: rtl/maa_pipe_adder.sv
// Two-stage multi-lane Mitchell approximate adder: the low m bits pass op2 through,
// the upper bits add exactly with carry-in op1[m-1].
module maa_pipe_adder #(
   parameter int LOG2_WIDTH = 4,
   parameter int WIDTH      = 2**LOG2_WIDTH,
   parameter int M_MAX      = 8,
   parameter int LANES      = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   maa_pipe_adder_if.slave  bus
);
   localparam int OPW = LOG2_WIDTH + WIDTH - 1;
   localparam int M_W = $clog2(M_MAX + 1);
   localparam int XW  = WIDTH - 1;
   localparam int KW  = LOG2_WIDTH + 1;
   localparam int LW  = LANES * OPW;

   localparam logic [M_W-1:0]   M_MAX_L = M_W'(M_MAX);
   localparam logic [M_W-1:0]   M_ONE   = M_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [OPW:0]     SUM_ONE = (OPW+1)'(1);

   function automatic logic [OPW:0] approx_sum(input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b,
                                               input logic [M_W-1:0] m);
      logic [OPW:0] a_w;
      logic [OPW:0] b_w;
      logic [OPW:0] lo_mask;
      logic [OPW:0] hi;
      logic         cin;
      a_w     = {1'b0, a};
      b_w     = {1'b0, b};
      lo_mask = ~({(OPW+1){1'b1}} << m);
      if (m != {M_W{1'b0}}) begin
         cin = |(a_w & (SUM_ONE << (m - M_ONE)));
      end else begin
         cin = 1'b0;
      end
      hi = (a_w >> m) + (b_w >> m) + {{OPW{1'b0}}, cin};
      approx_sum = (hi << m) | (b_w & lo_mask);
   endfunction

   logic [LW-1:0]        a_op1_q, a_op1_d;
   logic [LW-1:0]        a_op2_q, a_op2_d;
   logic [M_W-1:0]       a_m_q, a_m_d;
   logic                 va_q, va_d;
   logic [LANES*XW-1:0]  b_x_q, b_x_d;
   logic [LANES*KW-1:0]  b_k_q, b_k_d;
   logic                 vb_q, vb_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 in_ready_s;
   logic                 fire_in_s;
   logic                 load_b_s;
   logic                 fire_out_s;
   logic [M_W-1:0]       m_clamp_s;
   logic [OPW:0]         sum_s [LANES];

   // A frees up either because it is empty or because B takes its contents this cycle
   assign in_ready_s = !va_q || !vb_q || bus.out_ready;
   assign fire_in_s  = bus.in_valid && in_ready_s;
   assign load_b_s   = va_q && (!vb_q || bus.out_ready);
   assign fire_out_s = vb_q && bus.out_ready;
   assign m_clamp_s  = (bus.in_m > M_MAX_L) ? M_MAX_L : bus.in_m;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sum_s[l] = approx_sum(a_op1_q[l*OPW +: OPW], a_op2_q[l*OPW +: OPW], a_m_q);
      end
   end

   always_comb begin
      a_op1_d = a_op1_q;
      a_op2_d = a_op2_q;
      a_m_d   = a_m_q;
      va_d    = va_q;
      b_x_d   = b_x_q;
      b_k_d   = b_k_q;
      vb_d    = vb_q;
      cnt_d   = cnt_q;
      if (fire_in_s) begin
         a_op1_d = bus.in_op1;
         a_op2_d = bus.in_op2;
         a_m_d   = m_clamp_s;
         va_d    = 1'b1;
      end else if (load_b_s) begin
         va_d = 1'b0;
      end else begin
         va_d = va_q;
      end
      if (load_b_s) begin
         for (int l = 0; l < LANES; l++) begin
            b_x_d[l*XW +: XW] = sum_s[l][XW-1:0];
            b_k_d[l*KW +: KW] = sum_s[l][OPW:XW];
         end
         vb_d = 1'b1;
      end else if (fire_out_s) begin
         vb_d = 1'b0;
      end else begin
         vb_d = vb_q;
      end
      if (fire_out_s) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_op1_q <= {LW{1'b0}};
         a_op2_q <= {LW{1'b0}};
         a_m_q   <= {M_W{1'b0}};
         va_q    <= 1'b0;
         b_x_q   <= {(LANES*XW){1'b0}};
         b_k_q   <= {(LANES*KW){1'b0}};
         vb_q    <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         a_op1_q <= a_op1_d;
         a_op2_q <= a_op2_d;
         a_m_q   <= a_m_d;
         va_q    <= va_d;
         b_x_q   <= b_x_d;
         b_k_q   <= b_k_d;
         vb_q    <= vb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = vb_q;
   assign bus.out_x     = b_x_q;
   assign bus.out_k     = b_k_q;
   assign bus.txn_count = cnt_q;
endmodule

// File: tb/tb_maa_pipe_adder.sv
// Directed bench for maa_pipe_adder with two lanes of 19-bit log operands.
module tb_maa_pipe_adder;
   localparam int LOG2_WIDTH = 4;
   localparam int WIDTH      = 16;
   localparam int M_MAX      = 8;
   localparam int LANES      = 2;
   localparam int CNT_W      = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   maa_pipe_adder_if #(.LOG2_WIDTH(LOG2_WIDTH), .WIDTH(WIDTH), .M_MAX(M_MAX),
                       .LANES(LANES), .CNT_W(CNT_W)) bus ();

   maa_pipe_adder #(.LOG2_WIDTH(LOG2_WIDTH), .WIDTH(WIDTH), .M_MAX(M_MAX),
                    .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic logic [19:0] ref_sum(input logic [18:0] a, input logic [18:0] b,
                                           input logic [3:0] m);
      int     me;
      longint mask;
      longint cin;
      longint s;
      me   = (m > 4'd8) ? 8 : int'(m);
      mask = (longint'(1) << me) - 1;
      cin  = (me > 0) ? ((longint'(a) >> (me - 1)) & 1) : 0;
      s    = (longint'(a) & ~mask) + (longint'(b) & ~mask) + (cin << me) + (longint'(b) & mask);
      return s[19:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
   endtask

   task automatic send_one(input logic [37:0] op1, input logic [37:0] op2, input logic [3:0] m,
                           output logic [29:0] x, output logic [9:0] k,
                           output int lat, output logic acc);
      bus.in_op1    = op1;
      bus.in_op2    = op2;
      bus.in_m      = m;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      acc = bus.in_ready;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 8) begin
         tick();
         lat++;
      end
      x = bus.out_x;
      k = bus.out_k;
      tick();
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_m = 4'd0; bus.in_op1 = 38'd0; bus.in_op2 = 38'd0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      rst = 1'b0;
      tick();
      checks++; if (bus.txn_count !== 16'd0) begin failures++; $display("FAIL reset_txn_count: got %0d expected 0", bus.txn_count); end
      checks++; if (bus.out_x !== 30'd0 || bus.out_k !== 10'd0) begin failures++; $display("FAIL reset_outputs: got x=%h k=%h expected 0", bus.out_x, bus.out_k); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_approx_vs_exact();
      logic [29:0] x; logic [9:0] k; int lat; logic acc;
      send_one({19'h0, 19'h000FF}, {19'h0, 19'h00001}, 4'd8, x, k, lat, acc);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL approx_accept: got %b expected 1", acc); end
      checks++; if (x !== {15'h0, 15'h0101} || k !== 10'h0) begin failures++; $display("FAIL approx_m8: got x=%h k=%h expected x=%h k=0", x, k, {15'h0, 15'h0101}); end
      send_one({19'h0, 19'h000FF}, {19'h0, 19'h00001}, 4'd0, x, k, lat, acc);
      checks++; if (x !== {15'h0, 15'h0100} || k !== 10'h0) begin failures++; $display("FAIL exact_m0: got x=%h k=%h expected x=%h k=0", x, k, {15'h0, 15'h0100}); end
   endtask

   task automatic test_max_operands();
      logic [29:0] x; logic [9:0] k; int lat; logic acc;
      send_one({19'h7FFFF, 19'h7FFFF}, {19'h7FFFF, 19'h7FFFF}, 4'd0, x, k, lat, acc);
      checks++; if (x !== {15'h7FFE, 15'h7FFE} || k !== {5'h1F, 5'h1F}) begin failures++; $display("FAIL max_ops: got x=%h k=%h expected x=%h k=%h", x, k, {15'h7FFE, 15'h7FFE}, {5'h1F, 5'h1F}); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL max_latency: got %0d expected 2", lat); end
   endtask

   task automatic test_m_clamp();
      logic [29:0] x; logic [9:0] k; int lat; logic acc;
      send_one({19'h12345, 19'h000FF}, {19'h0F0F0, 19'h00001}, 4'd8, x, k, lat, acc);
      checks++; if (x !== {15'h13F0, 15'h0101} || k !== {5'h04, 5'h00}) begin failures++; $display("FAIL clamp_m8: got x=%h k=%h expected x=%h k=%h", x, k, {15'h13F0, 15'h0101}, {5'h04, 5'h00}); end
      send_one({19'h12345, 19'h000FF}, {19'h0F0F0, 19'h00001}, 4'd15, x, k, lat, acc);
      checks++; if (x !== {15'h13F0, 15'h0101} || k !== {5'h04, 5'h00}) begin failures++; $display("FAIL clamp_m15: got x=%h k=%h expected x=%h k=%h", x, k, {15'h13F0, 15'h0101}, {5'h04, 5'h00}); end
   endtask

   task automatic test_backpressure();
      int idx; int n; logic acc; logic [29:0] ex;
      apply_reset();
      bus.out_ready = 1'b0;
      bus.in_m = 4'd0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         bus.in_valid = (idx < 4);
         bus.in_op1 = {19'(idx + 1), 19'(idx + 1)};
         bus.in_op2 = {19'(idx + 1), 19'h00100};
         #1;
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) idx++;
         if (c >= 2) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_x !== {15'd2, 15'h101} || bus.out_k !== 10'd0) begin failures++; $display("FAIL bp_stable: got v=%b x=%h k=%h expected v=1 x=%h k=0", bus.out_valid, bus.out_x, bus.out_k, {15'd2, 15'h101}); end
         end
      end
      checks++; if (idx !== 2) begin failures++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
      bus.out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         bus.in_valid = (idx < 4);
         bus.in_op1 = {19'(idx + 1), 19'(idx + 1)};
         bus.in_op2 = {19'(idx + 1), 19'h00100};
         #1;
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            ex = {15'(2 * (n + 1)), 15'(256 + n + 1)};
            checks++; if (bus.out_x !== ex || bus.out_k !== 10'd0) begin failures++; $display("FAIL bp_order[%0d]: got x=%h k=%h expected x=%h k=0", n, bus.out_x, bus.out_k, ex); end
            n++;
         end
         tick();
         if (acc) idx++;
      end
      bus.in_valid = 1'b0;
      checks++; if (n !== 4 || idx !== 4) begin failures++; $display("FAIL bp_drain: got out=%0d in=%0d expected 4 4", n, idx); end
      checks++; if (bus.txn_count !== 16'd4) begin failures++; $display("FAIL bp_txn_count: got %0d expected 4", bus.txn_count); end
   endtask

   task automatic test_back_to_back();
      logic [37:0] s_op1 [100];
      logic [37:0] s_op2 [100];
      logic [3:0]  s_m   [100];
      logic [29:0] e_x   [100];
      logic [9:0]  e_k   [100];
      logic [19:0] s0, s1;
      int sent, rcv, stalls, first_c, last_c;
      logic acc;
      apply_reset();
      for (int i = 0; i < 100; i++) begin
         s_op1[i] = {19'($urandom_range(0, 524287)), 19'($urandom_range(0, 524287))};
         s_op2[i] = {19'($urandom_range(0, 524287)), 19'($urandom_range(0, 524287))};
         s_m[i]   = 4'($urandom_range(0, 15));
         s0 = ref_sum(s_op1[i][18:0], s_op2[i][18:0], s_m[i]);
         s1 = ref_sum(s_op1[i][37:19], s_op2[i][37:19], s_m[i]);
         e_x[i] = {s1[14:0], s0[14:0]};
         e_k[i] = {s1[19:15], s0[19:15]};
      end
      bus.out_ready = 1'b1;
      sent = 0; rcv = 0; stalls = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 300 && rcv < 100; c++) begin
         bus.in_valid = (sent < 100);
         if (sent < 100) begin
            bus.in_op1 = s_op1[sent]; bus.in_op2 = s_op2[sent]; bus.in_m = s_m[sent];
         end
         #1;
         acc = bus.in_valid && bus.in_ready;
         if (bus.in_valid && !bus.in_ready) stalls++;
         if (bus.out_valid) begin
            checks++; if (bus.out_x !== e_x[rcv] || bus.out_k !== e_k[rcv]) begin failures++; $display("FAIL stream[%0d]: got x=%h k=%h expected x=%h k=%h", rcv, bus.out_x, bus.out_k, e_x[rcv], e_k[rcv]); end
            if (first_c < 0) first_c = c;
            last_c = c;
            rcv++;
         end
         tick();
         if (acc) sent++;
      end
      bus.in_valid = 1'b0;
      checks++; if (rcv !== 100 || stalls !== 0) begin failures++; $display("FAIL stream_count: got rcv=%0d stalls=%0d expected 100 0", rcv, stalls); end
      checks++; if (last_c - first_c !== 99) begin failures++; $display("FAIL stream_bubbles: got span %0d expected 99", last_c - first_c); end
   endtask

   task automatic test_reset_midflight();
      logic [29:0] x; logic [9:0] k; int lat; logic acc; int stale;
      apply_reset();
      send_one({19'h1, 19'h1}, {19'h1, 19'h1}, 4'd0, x, k, lat, acc);
      send_one({19'h1, 19'h1}, {19'h1, 19'h1}, 4'd0, x, k, lat, acc);
      checks++; if (bus.txn_count !== 16'd2) begin failures++; $display("FAIL mid_pre_count: got %0d expected 2", bus.txn_count); end
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op1 = {19'h3, 19'h3}; bus.in_op2 = {19'h5, 19'h5}; bus.in_m = 4'd0;
      tick(); tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_full: got v=%b rdy=%b expected 1 0", bus.out_valid, bus.in_ready); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.txn_count !== 16'd0) begin failures++; $display("FAIL mid_txn_count: got %0d expected 0", bus.txn_count); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_x !== 30'd0 || bus.out_k !== 10'd0) begin failures++; $display("FAIL mid_outputs: got x=%h k=%h expected 0", bus.out_x, bus.out_k); end
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.out_valid) stale++;
      end
      checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale: got %0d stale results expected 0", stale); end
      send_one({19'h7, 19'h9}, {19'h2, 19'h4}, 4'd0, x, k, lat, acc);
      checks++; if (acc !== 1'b1 || x !== {15'h9, 15'hD} || lat !== 2) begin failures++; $display("FAIL mid_recover: got acc=%b x=%h lat=%0d expected 1 %h 2", acc, x, lat, {15'h9, 15'hD}); end
      checks++; if (bus.txn_count !== 16'd1) begin failures++; $display("FAIL mid_post_count: got %0d expected 1", bus.txn_count); end
   endtask

   initial begin
      test_reset();
      test_approx_vs_exact();
      test_max_operands();
      test_m_clamp();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
